// File: rtl/spectral_peak_detect_if.sv
// rtl/spectral_peak_detect_if.sv - power-stream input and peak-result output bundle
interface spectral_peak_detect_if #(
    parameter int BIN_W = 9
);
    logic [30:0]      power;
    logic             in_en;
    logic             frame_start;
    logic [30:0]      threshold;
    logic [BIN_W-1:0] peak_bin;
    logic [30:0]      peak_power;
    logic             detected;
    logic             out_en;
    logic             frame_err;

    // Upstream side: drives samples and threshold, observes results
    modport master (
        output power, in_en, frame_start, threshold,
        input  peak_bin, peak_power, detected, out_en, frame_err
    );

    // Detector side
    modport slave (
        input  power, in_en, frame_start, threshold,
        output peak_bin, peak_power, detected, out_en, frame_err
    );
endinterface

// File: rtl/spectral_peak_detect.sv
// rtl/spectral_peak_detect.sv - per-frame windowed power peak search with threshold detect
module spectral_peak_detect #(
    parameter int N_BINS  = 512,
    parameter int BIN_W   = 9,
    parameter int MIN_BIN = 1,
    parameter int MAX_BIN = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    spectral_peak_detect_if.slave bus
);
    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [BIN_W-1:0] MIN_IDX  = BIN_W'(MIN_BIN);
    localparam logic [BIN_W-1:0] MAX_IDX  = BIN_W'(MAX_BIN);
    localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(N_BINS - 1);

    state_t           state_q, state_d;
    logic [BIN_W-1:0] cnt_q, cnt_d;
    logic [30:0]      max_q, max_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BIN_W-1:0] peak_bin_q, peak_bin_d;
    logic [30:0]      peak_power_q, peak_power_d;
    logic             detected_q, detected_d;
    logic             out_en_q, out_en_d;
    logic             frame_err_q, frame_err_d;

    logic             accept;
    logic [BIN_W-1:0] idx;
    logic             in_window;

    // Next-state: sample acceptance, window search, frame end and early-restart handling
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        max_d        = max_q;
        bin_d        = bin_q;
        peak_bin_d   = peak_bin_q;
        peak_power_d = peak_power_q;
        detected_d   = detected_q;
        out_en_d     = 1'b0;
        frame_err_d  = 1'b0;

        // In IDLE only a frame_start sample is taken; frame_start always forces bin 0
        accept    = bus.in_en && ((state_q == ACCUM) || bus.frame_start);
        idx       = bus.frame_start ? '0 : cnt_q;
        in_window = (idx >= MIN_IDX) && (idx <= MAX_IDX);

        if (accept) begin
            state_d = ACCUM;
            cnt_d   = idx + BIN_W'(1);

            // A restart anywhere but the expected boundary drops the partial frame
            if ((state_q == ACCUM) && bus.frame_start && (cnt_q != '0)) begin
                frame_err_d = 1'b1;
            end

            // First window bin seeds the search; later bins need a strict win so ties keep the lowest bin
            if (in_window) begin
                if ((idx == MIN_IDX) || (bus.power > max_q)) begin
                    max_d = bus.power;
                    bin_d = idx;
                end
            end

            // Last bin publishes the result including its own contribution
            if (idx == LAST_IDX) begin
                out_en_d     = 1'b1;
                peak_bin_d   = bin_d;
                peak_power_d = max_d;
                detected_d   = (max_d >= bus.threshold);
            end
        end
    end

    // State and registered outputs; async reset discards any partial frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            max_q        <= '0;
            bin_q        <= '0;
            peak_bin_q   <= '0;
            peak_power_q <= '0;
            detected_q   <= 1'b0;
            out_en_q     <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            max_q        <= max_d;
            bin_q        <= bin_d;
            peak_bin_q   <= peak_bin_d;
            peak_power_q <= peak_power_d;
            detected_q   <= detected_d;
            out_en_q     <= out_en_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.peak_bin   = peak_bin_q;
    assign bus.peak_power = peak_power_q;
    assign bus.detected   = detected_q;
    assign bus.out_en     = out_en_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: doc/spectral_peak_detect.md
Name: spectral_peak_detect

Overview:
- Sits directly downstream of the magnitude-squared stage and consumes its 31-bit unsigned power stream, one value per FFT bin.
- Within each frame, searches a configurable bin window for the largest power and reports that bin's index and power.
- Flags whether the peak meets a programmable threshold; this is the detection decision for the wing-beat band.
- Emits a one-cycle result strobe per completed frame and flags framing errors.

Parameters:
- N_BINS, 512, bins per frame (power of two, ≥4)
- BIN_W, 9, bin index width, equal to log2(N_BINS)
- MIN_BIN, 1, first bin searched, inclusive (skips DC)
- MAX_BIN, 255, last bin searched, inclusive; requires MIN_BIN ≤ MAX_BIN < N_BINS

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- power  in  31  unsigned bin power from upstream
- in_en  in  1  power valid this cycle
- frame_start  in  1  marks the current in_en sample as bin 0; ignored when in_en=0
- threshold  in  31  unsigned detection threshold; quasi-static
- peak_bin  out  BIN_W  index of max-power bin in window
- peak_power  out  31  power of that bin
- detected  out  1  peak_power ≥ threshold
- out_en  out  1  one-cycle strobe; result outputs valid
- frame_err  out  1  one-cycle strobe; frame aborted by early frame_start

Behaviour:
- Reset (async): all outputs 0; bin counter 0; running max 0; running bin 0; state IDLE.
- State IDLE:
  - in_en samples without frame_start are discarded.
  - in_en & frame_start: the sample is processed as bin 0; go to ACCUM.
- State ACCUM:
  - Each in_en sample gets index cnt; cnt then increments.
  - Gaps in in_en are allowed; cnt and running state hold during gaps.
- Window search, for an accepted sample with index i where MIN_BIN ≤ i ≤ MAX_BIN:
  - If i == MIN_BIN: load max ← power, bin ← i unconditionally.
  - Otherwise: update only if power > max (strict), so ties keep the lowest bin.
  - Samples outside the window do not affect max or bin.
- Frame end: when the sample with index N_BINS-1 is accepted, on the next clock:
  - out_en=1 for exactly one cycle.
  - peak_bin and peak_power load the final running values; this includes that last sample if it falls in the window.
  - detected ← (final max ≥ threshold), using threshold sampled on that same edge.
  - cnt wraps to 0 and the state stays ACCUM: free-running frames need no further frame_start.
  - Latency is 1 cycle from the last-bin sample to out_en.
- Result outputs hold their values until the next out_en; they do not change on frame_err.
- frame_start with in_en while in ACCUM:
  - If cnt == 0 (expected boundary): normal bin 0.
  - If cnt ≠ 0: abort the partial frame (no out_en). On the next cycle frame_err=1 for one cycle. The current sample is processed as bin 0 of the new frame.
- Simultaneous events: a sample that is both index N_BINS-1 and frame_start is impossible; frame_start forces index 0. If the bin-0 processing of a new frame coincides with the out_en cycle of the previous frame, both proceed independently.
- Arithmetic: unsigned 31-bit compares only; no accumulation; no overflow cases.
- Reset mid-frame: partial frame discarded silently; no out_en, no frame_err; back to IDLE.
- Implementation is fully synchronous apart from the async reset; no combinational path from inputs to outputs.

Test Plan:
- Bench uses N_BINS=8, MIN_BIN=1, MAX_BIN=5, threshold=100.
- Basic frame: frame_start with powers [900,10,50,300,20,70,999,5] -> out_en one cycle after bin 7; peak_bin=3, peak_power=300, detected=1; DC (900) and bin 6 (999) ignored.
- Ties and below threshold: [0,40,40,40,0,0,0,0] -> peak_bin=1, peak_power=40, detected=0. All-zero frame -> peak_bin=1, peak_power=0, detected=0.
- Free-run and gaps:
  - Two back-to-back frames with only the first frame_start, in_en toggled 1-0-1 -> two out_en pulses, each one cycle after its bin-7 sample; second result peak_bin=5 when bin 5 holds the unique max; no frame_err.
  - Pre-sync: in_en samples before any frame_start -> no out_en.
- Early frame_start: frame_start reasserted at bin 4 -> frame_err pulse next cycle, no out_en; the new frame of 8 samples then completes normally with correct peak.
- Reset mid-frame: assert rst at bin 3 -> all outputs 0 immediately; subsequent samples without frame_start produce no out_en; after a frame_start, a full frame produces a correct result.
